// File: rtl/tilt_rate_gen_if.sv
// Sample/step bus for tilt_rate_gen.
//   accel_x, accel_y : signed 12-bit acceleration samples
//   sample_valid     : one-cycle strobe, both samples valid together
//   x_inc/x_dec/y_inc/y_dec : one-cycle step pulses toward the ball module
//   tilt             : {y_neg, y_pos, x_neg, x_pos} direction levels
//   mag_x, mag_y     : per-axis magnitude level 0..15
// master = sample source / step consumer, slave = tilt_rate_gen.
interface tilt_rate_gen_if;
  logic [11:0] accel_x;
  logic [11:0] accel_y;
  logic        sample_valid;
  logic        x_inc;
  logic        x_dec;
  logic        y_inc;
  logic        y_dec;
  logic [3:0]  tilt;
  logic [3:0]  mag_x;
  logic [3:0]  mag_y;

  modport master (
    output accel_x, accel_y, sample_valid,
    input  x_inc, x_dec, y_inc, y_dec, tilt, mag_x, mag_y
  );

  modport slave (
    input  accel_x, accel_y, sample_valid,
    output x_inc, x_dec, y_inc, y_dec, tilt, mag_x, mag_y
  );
endinterface

// File: rtl/tilt_rate_gen.sv
// Converts raw signed X/Y accelerometer samples into per-axis direction
// levels, magnitude levels and rate-scaled step pulses for the ball module.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : tilt_rate_gen_if.slave (samples in, steps/tilt/magnitudes out)
// Axis index 0 = X, 1 = Y throughout.
module tilt_rate_gen #(
  parameter int          SIMULATE    = 0,
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int          DEADZONE    = 100,
  parameter int          HYST        = 16,
  parameter int unsigned MAG_SHIFT   = 6,
  parameter int          MAX_PERIOD  = 64,
  parameter int          PERIOD_STEP = 4
) (
  input  logic           clk,
  input  logic           reset,
  tilt_rate_gen_if.slave bus
);

  localparam int unsigned DIV    = (SIMULATE != 0) ? 4 : TICK_DIV;
  localparam int unsigned ACC_W  = 12 + AVG_LOG2;
  localparam int unsigned CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned LAST   = (1 << AVG_LOG2) - 1;
  localparam int unsigned STEP_W = $clog2(MAX_PERIOD + 1);

  typedef enum logic [1:0] {NEUTRAL, POS, NEG} dir_t;

  // ---------------- block averaging ----------------
  logic signed [11:0]      smp [2];
  logic signed [ACC_W-1:0] acc [2];
  logic signed [ACC_W-1:0] sum [2];
  logic signed [11:0]      avg [2];
  logic [CNT_W-1:0]        count;
  logic                    avg_valid;

  assign smp[0] = bus.accel_x;
  assign smp[1] = bus.accel_y;

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      sum[i] = acc[i] + ACC_W'(smp[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      avg_valid <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        acc[i] <= '0;
        avg[i] <= '0;
      end
    end else begin
      avg_valid <= 1'b0;
      if (bus.sample_valid) begin
        if (count == CNT_W'(LAST)) begin
          count     <= '0;
          avg_valid <= 1'b1;
          for (int unsigned i = 0; i < 2; i++) begin
            acc[i] <= '0;
            avg[i] <= 12'(sum[i] >>> AVG_LOG2);
          end
        end else begin
          count <= count + CNT_W'(1);
          for (int unsigned i = 0; i < 2; i++) begin
            acc[i] <= sum[i];
          end
        end
      end
    end
  end

  // ---------------- direction FSM and magnitude ----------------
  function automatic dir_t next_dir(input dir_t cur, input logic signed [11:0] avg_in);
    int a;
    a = int'(avg_in);
    next_dir = cur;
    case (cur)
      NEUTRAL: begin
        if (a > DEADZONE)       next_dir = POS;
        else if (a < -DEADZONE) next_dir = NEG;
      end
      POS: begin
        if (a < -DEADZONE)              next_dir = NEG;
        else if (a < DEADZONE - HYST)   next_dir = NEUTRAL;
      end
      NEG: begin
        if (a > DEADZONE)               next_dir = POS;
        else if (a > -(DEADZONE - HYST)) next_dir = NEUTRAL;
      end
      default: next_dir = NEUTRAL;
    endcase
  endfunction

  // |avg| with -2048 saturating to 2047, excess over deadzone, scaled and clamped.
  function automatic logic [3:0] level_of(input logic signed [11:0] avg_in);
    int a;
    int ex;
    a = int'(avg_in);
    if (a < 0)    a = -a;
    if (a > 2047) a = 2047;
    ex = a - DEADZONE;
    if (ex < 0) ex = 0;
    ex = ex >>> MAG_SHIFT;
    if (ex > 15) ex = 15;
    return 4'(ex);
  endfunction

  dir_t       dir_q [2];
  dir_t       dir_d [2];
  logic [3:0] lvl_q [2];
  logic [3:0] lvl_d [2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        dir_q[i] <= NEUTRAL;
        lvl_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        dir_q[i] <= dir_d[i];
        lvl_q[i] <= lvl_d[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      dir_d[i] = dir_q[i];
      lvl_d[i] = lvl_q[i];
      if (avg_valid) begin
        dir_d[i] = next_dir(dir_q[i], avg[i]);
        lvl_d[i] = (dir_d[i] == NEUTRAL) ? 4'd0 : level_of(avg[i]);
      end
    end
  end

  // ---------------- rate tick and step generation ----------------
  logic [31:0] presc;
  logic        tick;

  assign tick = (presc == 32'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) presc <= '0;
    else        presc <= tick ? '0 : presc + 32'd1;
  end

  function automatic int period_of(input logic [3:0] lvl);
    int p;
    p = MAX_PERIOD - int'(lvl) * PERIOD_STEP;
    if (p < 1) p = 1;
    return p;
  endfunction

  logic [STEP_W-1:0] stp  [2];
  logic              fire [2];

  // Pulses decode from the registered direction/level, so a tick that
  // coincides with an FSM update still steps with the old settings.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      fire[i] = tick && (dir_q[i] != NEUTRAL) &&
                (int'(stp[i]) >= period_of(lvl_q[i]) - 1);
    end
  end

  // Direction change clears the counter (full period to first pulse);
  // a level-only change keeps it so the new period applies at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 2; i++) stp[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (dir_d[i] != dir_q[i] || dir_q[i] == NEUTRAL) stp[i] <= '0;
        else if (tick) stp[i] <= fire[i] ? '0 : stp[i] + STEP_W'(1);
      end
    end
  end

  assign bus.x_inc = fire[0] && (dir_q[0] == POS);
  assign bus.x_dec = fire[0] && (dir_q[0] == NEG);
  assign bus.y_inc = fire[1] && (dir_q[1] == POS);
  assign bus.y_dec = fire[1] && (dir_q[1] == NEG);
  assign bus.tilt  = {dir_q[1] == NEG, dir_q[1] == POS, dir_q[0] == NEG, dir_q[0] == POS};
  assign bus.mag_x = lvl_q[0];
  assign bus.mag_y = lvl_q[1];

endmodule
